// File: rtl/ospfb_frame_capture_pkg.sv
// rtl/ospfb_frame_capture_pkg.sv - shared capture FSM state type and default capture depth
package alpaca_ospfb_constants_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2,
        FULL    = 2'd3
    } capture_state_t;

    localparam int CAPTURE_FRAMES = 32;

endpackage

// File: rtl/ospfb_frame_capture_if.sv
// rtl/ospfb_frame_capture_if.sv - complex-sample stream between the OSPFB FFT output and the capture buffer
interface ospfb_frame_capture_if #(
    parameter int WIDTH = 16
);
    logic [2*WIDTH-1:0] tdata;
    logic               tvalid;
    logic               tlast;
    logic               tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ospfb_frame_capture_sdp_ram.sv
// rtl/ospfb_frame_capture_sdp_ram.sv - simple dual-port RAM, one write port, registered read (old data on collision)
module capture_sdp_ram #(
    parameter int  W     = 32,
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];

    // storage is deliberately left unreset so partial captures survive a reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/ospfb_frame_capture.sv
// rtl/ospfb_frame_capture.sv - frame-aligned FFT capture buffer; OSPFB_CAPTURE_FRAME_ALIGN_EN enables the SYNC state
module ospfb_frame_capture
    import alpaca_ospfb_constants_pkg::*;
#(
    parameter int  WIDTH   = 16,
    parameter int  FFT_LEN = 64,
    parameter int  FRAMES  = CAPTURE_FRAMES,
    localparam int DEPTH   = FRAMES * FFT_LEN,
    localparam int AW      = $clog2(DEPTH),
    localparam int FCW     = $clog2(FRAMES) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ospfb_frame_capture_if.slave   s_axis,
    input  logic                   arm,
    output logic                   busy,
    output logic                   full,
    output logic [FCW-1:0]         frame_cnt,
    output logic                   tlast_unexpected,
    output logic                   tlast_missing,
    input  logic [AW-1:0]          rd_addr,
    output logic [2*WIDTH-1:0]     rd_data
);
    localparam int             BW        = $clog2(FFT_LEN);
    localparam logic [BW-1:0]  BIN_LAST  = BW'(FFT_LEN - 1);
    localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);

`ifdef OSPFB_CAPTURE_FRAME_ALIGN_EN
    localparam capture_state_t ARM_TARGET = SYNC;
`else
    localparam capture_state_t ARM_TARGET = CAPTURE;
`endif

    capture_state_t state, state_nxt;
    logic [AW-1:0]  wr_addr;
    logic [BW-1:0]  bin_idx;
    logic           tready_q;
    logic           beat;
    logic           wr_en;
    logic           arm_take;

    assign s_axis.tready = tready_q;
    assign beat          = s_axis.tvalid & tready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FULL: begin
                if (arm) state_nxt = ARM_TARGET;
            end
`ifdef OSPFB_CAPTURE_FRAME_ALIGN_EN
            SYNC: begin
                if (beat && s_axis.tlast) state_nxt = CAPTURE;
            end
`endif
            CAPTURE: begin
                if (beat && wr_addr == ADDR_LAST) state_nxt = FULL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // arm only acts from IDLE/FULL; a beat arriving with that arm is dropped
    always_comb begin
        busy     = (state == SYNC) || (state == CAPTURE);
        full     = (state == FULL);
        wr_en    = (state == CAPTURE) && beat;
        arm_take = arm && ((state == IDLE) || (state == FULL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready_q         <= 1'b0;
            wr_addr          <= '0;
            bin_idx          <= '0;
            frame_cnt        <= '0;
            tlast_unexpected <= 1'b0;
            tlast_missing    <= 1'b0;
        end else begin
            tready_q         <= 1'b1;
            tlast_unexpected <= 1'b0;
            tlast_missing    <= 1'b0;
            if (arm_take) begin
                wr_addr   <= '0;
                bin_idx   <= '0;
                frame_cnt <= '0;
            end else if (wr_en) begin
                // bin_idx is purely positional; a bad tlast never resynchronises it
                wr_addr          <= wr_addr + 1'b1;
                bin_idx          <= bin_idx + 1'b1;
                tlast_unexpected <= s_axis.tlast && (bin_idx != BIN_LAST);
                tlast_missing    <= !s_axis.tlast && (bin_idx == BIN_LAST);
                if (bin_idx == BIN_LAST) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    capture_sdp_ram #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_axis.tdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_ospfb_frame_capture.sv
// tb/tb_ospfb_frame_capture.sv - directed scoreboard bench for ospfb_frame_capture (FFT_LEN=64, FRAMES=4)
module tb_ospfb_frame_capture;
    localparam int WIDTH   = 16;
    localparam int FFT_LEN = 64;
    localparam int FRAMES  = 4;
    localparam int DEPTH   = FRAMES * FFT_LEN;
    localparam int AW      = $clog2(DEPTH);
    localparam int FCW     = $clog2(FRAMES) + 1;
`ifdef OSPFB_CAPTURE_FRAME_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [31:0] WORD0_BIN = ALIGN ? 32'd0 : 32'd21;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 arm = 1'b0;
    logic                 busy, full, tlast_unexpected, tlast_missing;
    logic [FCW-1:0]       frame_cnt;
    logic [AW-1:0]        rd_addr = '0;
    logic [2*WIDTH-1:0]   rd_data;

    ospfb_frame_capture_if #(.WIDTH(WIDTH)) s_axis_if ();

    ospfb_frame_capture #(
        .WIDTH   (WIDTH),
        .FFT_LEN (FFT_LEN),
        .FRAMES  (FRAMES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis           (s_axis_if),
        .arm              (arm),
        .busy             (busy),
        .full             (full),
        .frame_cnt        (frame_cnt),
        .tlast_unexpected (tlast_unexpected),
        .tlast_missing    (tlast_missing),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data)
    );

    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] ref_ram [DEPTH];
    logic [31:0] src_g;
    int          src_bin;
    int          m_state, m_addr, m_frames;
    bit          e_unexp, e_miss, inject;
    int          n_unexp_dut, n_miss_dut, n_unexp_exp, n_miss_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: check the previous cycle's outcome, then drive a new cycle and advance the model
    task automatic step(input bit v, input bit a);
        logic last;
        int   pos;
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
        chk("full", 32'(full), 32'(m_state == 3));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        chk("tready", 32'(s_axis_if.tready), 32'd1);
        chk("tlast_unexpected", 32'(tlast_unexpected), 32'(e_unexp));
        chk("tlast_missing", 32'(tlast_missing), 32'(e_miss));
        if (tlast_unexpected) n_unexp_dut++;
        if (tlast_missing) n_miss_dut++;
        e_unexp = 1'b0;
        e_miss  = 1'b0;
        pos  = m_addr % FFT_LEN;
        last = v && (src_bin == FFT_LEN - 1);
        if (inject && v && m_state == 2) begin
            if (m_addr == 2 * FFT_LEN + 10) last = 1'b1;
            if (m_addr == 2 * FFT_LEN + 63) last = 1'b0;
        end
        s_axis_if.tvalid = v;
        s_axis_if.tlast  = last;
        s_axis_if.tdata  = src_g;
        arm              = a;
        case (m_state)
            0, 3: if (a) begin
                m_addr = 0; m_frames = 0; m_state = ALIGN ? 1 : 2;
            end
            1: if (v && last) m_state = 2;
            2: if (v) begin
                sb.push_back(src_g);
                if (last && pos != FFT_LEN - 1) begin e_unexp = 1'b1; n_unexp_exp++; end
                if (!last && pos == FFT_LEN - 1) begin e_miss = 1'b1; n_miss_exp++; end
                if (pos == FFT_LEN - 1) m_frames++;
                m_addr++;
                if (m_addr == DEPTH) m_state = 3;
            end
            default: ;
        endcase
        if (v) begin
            src_g++;
            src_bin = (src_bin + 1) % FFT_LEN;
        end
    endtask

    task automatic arm_at_bin20(input bit gapped);
        src_g = 0;
        src_bin = 0;
        for (int i = 0; i < 200 && src_bin != 20; i++) step(gapped ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        step(1'b1, 1'b1);
    endtask

    task automatic run_capture(input bit gapped);
        bit rearmed = 1'b0;
        bit a;
        arm_at_bin20(gapped);
        for (int guard = 0; guard < 3000 && m_state != 3; guard++) begin
            a = gapped && !rearmed && m_state == 2 && m_addr >= 100;
            step(gapped ? 1'($urandom_range(0, 1)) : 1'b1, a);
            if (a) rearmed = 1'b1;
        end
        step(1'b0, 1'b0);
        chk("full_after_capture", 32'(full), 32'd1);
        chk("frame_cnt_final", 32'(frame_cnt), 32'(FRAMES));
    endtask

    task automatic readback(input bit save_ref, input bit cmp_ref);
        logic [31:0] exp;
        chk("sb_size", 32'(sb.size()), 32'(DEPTH));
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 32'hdead_beef;
                chk("rd_data", rd_data, exp);
                if (save_ref) ref_ram[i-1] = exp;
                if (cmp_ref) chk("rd_vs_ungapped", rd_data, ref_ram[i-1]);
                if (i == 1) chk("word0_bin", 32'(rd_data[5:0]), WORD0_BIN);
            end
            if (i < DEPTH) rd_addr = AW'(i);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_tready", 32'(s_axis_if.tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_unexp", 32'(tlast_unexpected), 32'd0);
        chk("rst_miss", 32'(tlast_missing), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
    endtask

    initial begin
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
        s_axis_if.tdata  = '0;
        m_state = 0; m_addr = 0; m_frames = 0;
        e_unexp = 1'b0; e_miss = 1'b0; inject = 1'b0;
        n_unexp_dut = 0; n_miss_dut = 0; n_unexp_exp = 0; n_miss_exp = 0;
        src_g = 0; src_bin = 0;

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // stream without arm: nothing captured, block stays idle
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_frame_cnt", 32'(frame_cnt), 32'd0);

        // ungapped reference capture armed mid-frame
        run_capture(1'b0);
        readback(1'b1, 1'b0);

        // framing faults in frame 2
        inject = 1'b1;
        run_capture(1'b0);
        inject = 1'b0;
        chk("unexp_total", 32'(n_unexp_dut), 32'(n_unexp_exp));
        chk("miss_total", 32'(n_miss_dut), 32'(n_miss_exp));
        readback(1'b0, 1'b1);

        // gapped tvalid with a stray arm during capture
        run_capture(1'b1);
        readback(1'b0, 1'b1);

        // reset mid-capture, then a clean re-arm
        arm_at_bin20(1'b0);
        for (int i = 0; i < 400 && !(m_state == 2 && m_addr >= 100); i++) step(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        s_axis_if.tvalid = 1'b0;
        arm = 1'b0;
        m_state = 0; m_addr = 0; m_frames = 0;
        e_unexp = 1'b0; e_miss = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_capture(1'b0);
        readback(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
